// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined arithmetic unit: function codes, result flags,
// and the width-generic (WIDTH+1)-bit function evaluator.
package arith_pkg;

  // Widest operand supported by arith_compute; instances must use WIDTH < MAXW.
  localparam int MAXW = 64;

  localparam logic [3:0] SEL_PASS_A       = 4'b0000;
  localparam logic [3:0] SEL_OR           = 4'b0001;
  localparam logic [3:0] SEL_OR_NB        = 4'b0010;
  localparam logic [3:0] SEL_ONES         = 4'b0011;
  localparam logic [3:0] SEL_A_OR_ANB     = 4'b0100;
  localparam logic [3:0] SEL_ORB_ADD_ANB  = 4'b0101;
  localparam logic [3:0] SEL_SUB_DEC      = 4'b0110;
  localparam logic [3:0] SEL_ANB_DEC      = 4'b0111;
  localparam logic [3:0] SEL_A_ADD_AB     = 4'b1000;
  localparam logic [3:0] SEL_ADD          = 4'b1001;
  localparam logic [3:0] SEL_ORNB_ADD_AB  = 4'b1010;
  localparam logic [3:0] SEL_AB_DEC       = 4'b1011;
  localparam logic [3:0] SEL_DBL          = 4'b1100;
  localparam logic [3:0] SEL_ORB_ADD_A    = 4'b1101;
  localparam logic [3:0] SEL_ORNB_ADD_A   = 4'b1110;
  localparam logic [3:0] SEL_DEC_A        = 4'b1111;

  typedef struct packed {
    logic carry;
    logic compare;
    logic zero;
    logic negative;
    logic overflow;
  } flags_t;

  // Operands arrive zero-extended; w is the real operand width. Bit w of the
  // return value is the carry, everything above it is zero.
  function automatic logic [MAXW:0] arith_compute(input logic [MAXW:0] a,
                                                  input logic [MAXW:0] b,
                                                  input logic [3:0]    sel,
                                                  input logic          c,
                                                  input int unsigned   w);
    logic [MAXW:0] xm, wm, nbx, nbw, ci, r;
    xm  = {(MAXW+1){1'b1}} >> (MAXW - int'(w));
    wm  = xm >> 1;
    // Only 0010/0110 see ~B with its extension bit set.
    nbx = ~b & xm;
    nbw = ~b & wm;
    ci  = {{MAXW{1'b0}}, c};
    case (sel)
      SEL_PASS_A:      r = a & wm;
      SEL_OR:          r = (a | b) & wm;
      SEL_OR_NB:       r = (a | nbx) & wm;
      SEL_ONES:        r = wm;
      SEL_A_OR_ANB:    r = (a | (a & nbw)) & wm;
      SEL_ORB_ADD_ANB: r = ((a | b) + (a & nbw) + ci) & xm;
      SEL_SUB_DEC:     r = (a + nbx) & xm;
      SEL_ANB_DEC:     r = ((a & nbw) + xm) & xm;
      SEL_A_ADD_AB:    r = (a + (a & b) + ci) & xm;
      SEL_ADD:         r = (a + b + ci) & xm;
      SEL_ORNB_ADD_AB: r = ((a | nbw) + (a & b) + ci) & xm;
      SEL_AB_DEC:      r = ((a & b) + xm) & xm;
      SEL_DBL:         r = (a + a + ci) & xm;
      SEL_ORB_ADD_A:   r = ((a | b) + a + ci) & xm;
      SEL_ORNB_ADD_A:  r = ((a | nbw) + a + ci) & xm;
      default:         r = (a + xm) & xm;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arith_core.sv
// Combinational WIDTH-bit function unit: result, carry and signed overflow.
module arith_core
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [MAXW:0]         full;
  logic [MAXW-WIDTH-1:0] unused_hi;

  always_comb begin
    full = arith_compute({{(MAXW+1-WIDTH){1'b0}}, a_i},
                         {{(MAXW+1-WIDTH){1'b0}}, b_i},
                         sel_i, c_i, WIDTH);
  end

  assign {unused_hi, carry_o, res_o} = full;

  assign overflow_o = (sel_i == SEL_ADD) && (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                      (res_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/arithmetic_unit_pipe.sv
// Two-stage arithmetic unit: S1 captures the operand beat, S2 holds the computed
// result and flags. carry_flag feeds chained multi-word operations.
module arithmetic_unit_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       sel,
  input  logic             carry_in,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] arithmetic_out,
  output logic             carry_out,
  output logic             compare,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  logic             s1_vld_q, s1_vld_d, s1_cin_q, s1_cin_d, s1_chain_q, s1_chain_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [3:0]       s1_sel_q, s1_sel_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  flags_t           s2_flags_q, s2_flags_d;
  logic             carry_flag_q, carry_flag_d;

  logic             s2_adv, c_eff, core_carry, core_ovf;
  logic [WIDTH-1:0] core_res;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_adv;
  assign c_eff    = (s1_chain_q && CHAIN_EN) ? carry_flag_q : s1_cin_q;

  arith_core #(.WIDTH(WIDTH)) u_core (
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .sel_i     (s1_sel_q),
    .c_i       (c_eff),
    .res_o     (core_res),
    .carry_o   (core_carry),
    .overflow_o(core_ovf)
  );

  always_comb begin
    s1_vld_d     = s1_vld_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_sel_d     = s1_sel_q;
    s1_cin_d     = s1_cin_q;
    s1_chain_d   = s1_chain_q;
    s2_vld_d     = s2_vld_q;
    s2_res_d     = s2_res_q;
    s2_flags_d   = s2_flags_q;
    carry_flag_d = carry_flag_q;
    if (in_ready) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_sel_d   = sel;
        s1_cin_d   = carry_in;
        s1_chain_d = chain;
      end
    end
    // The op is evaluated as it moves S1 -> S2; carry_flag only changes then.
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_res_d            = core_res;
        s2_flags_d.carry    = core_carry;
        s2_flags_d.compare  = (s1_a_q == s1_b_q);
        s2_flags_d.zero     = (core_res == '0);
        s2_flags_d.negative = core_res[WIDTH-1];
        s2_flags_d.overflow = core_ovf;
        carry_flag_d        = core_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_sel_q     <= '0;
      s1_cin_q     <= 1'b0;
      s1_chain_q   <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_res_q     <= '0;
      s2_flags_q   <= '0;
      carry_flag_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_sel_q     <= s1_sel_d;
      s1_cin_q     <= s1_cin_d;
      s1_chain_q   <= s1_chain_d;
      s2_vld_q     <= s2_vld_d;
      s2_res_q     <= s2_res_d;
      s2_flags_q   <= s2_flags_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign out_valid      = s2_vld_q;
  assign arithmetic_out = s2_res_q;
  assign carry_out      = s2_flags_q.carry;
  assign compare        = s2_flags_q.compare;
  assign zero           = s2_flags_q.zero;
  assign negative       = s2_flags_q.negative;
  assign overflow       = s2_flags_q.overflow;

endmodule
